divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 77 +++++++
 tb/tb_divider.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider: 64-bit iterative restoring divider for UDIV/SDIV.
// Fixed 66-cycle latency: 64 CALC steps, one FIXUP, one DONE.
module divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_start,
    input  logic        div_mode,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] div_result,
    output logic        divider_done,
    output logic        div_busy
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;
    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] rem_q, quo_q, dvs_q, res_q;
    logic        neg_q, dz_q, done_q;
    logic [63:0] mag_a_d, mag_b_d, rem_d, quo_d, res_d;
    logic [64:0] shift_d, trial_d;
    logic        ge_d;
    always_comb begin
        mag_a_d = (div_mode && dividend[63]) ? -dividend : dividend;
        mag_b_d = (div_mode && divisor[63]) ? -divisor : divisor;
        shift_d = {rem_q, quo_q[63]};
        // remainder < divisor, so the 65-bit difference never overflows its sign bit
        trial_d = shift_d - {1'b0, dvs_q};
        ge_d    = ~trial_d[64];
        rem_d   = ge_d ? trial_d[63:0] : shift_d[63:0];
        quo_d   = {quo_q[62:0], ge_d};
        res_d   = dz_q ? '0 : neg_q ? -quo_q : quo_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (div_start) begin
                    rem_q   <= '0;
                    quo_q   <= mag_a_d;
                    dvs_q   <= mag_b_d;
                    neg_q   <= div_mode & (dividend[63] ^ divisor[63]);
                    dz_q    <= (divisor == '0);
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_q <= FIXUP;
                end
                FIXUP: begin
                    res_q   <= res_d;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign div_result   = res_q;
    assign divider_done = done_q;
    assign div_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed checks of divider against a cycle-counting arithmetic model.
module tb_divider;
    logic        clk = 1'b0, rst_n = 1'b1, div_start = 1'b0, div_mode = 1'b0;
    logic [63:0] dividend = '0, divisor = '0;
    logic [63:0] div_result;
    logic        divider_done, div_busy;
    int          checks = 0, fails = 0;
    int          m_cnt = 0;
    logic [63:0] m_res = '0, m_pend = '0;
    logic        m_done = 1'b0;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] N100 = 64'hFFFF_FFFF_FFFF_FF9C;
    localparam logic [63:0] N7 = 64'hFFFF_FFFF_FFFF_FFF9;
    localparam logic [63:0] N14 = 64'hFFFF_FFFF_FFFF_FFF2;

    divider dut (
        .clk(clk), .rst_n(rst_n), .div_start(div_start), .div_mode(div_mode),
        .dividend(dividend), .divisor(divisor), .div_result(div_result),
        .divider_done(divider_done), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic m, input logic [63:0] a, input logic [63:0] b);
        if (b == '0) return '0;
        if (!m) return a / b;
        if (a == MIN && b == '1) return MIN;
        return 64'($signed(a) / $signed(b));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // model: an accepted op completes 66 edges later; result visible one cycle before done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_res <= '0; m_pend <= '0; m_done <= 1'b0;
        end else begin
            m_done <= (m_cnt == 1);
            if (m_cnt == 0) begin
                if (div_start) begin
                    m_cnt  <= 66;
                    m_pend <= ref_div(div_mode, dividend, divisor);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 2) m_res <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        check("done", {63'b0, divider_done}, {63'b0, m_done});
        check("busy", {63'b0, div_busy}, {63'b0, m_cnt != 0});
        check("result", div_result, m_res);
    end

    // Called at a negedge with the divider idle; leaves div_start high so calls chain back-to-back.
    task automatic run_op(input logic m, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input string nm);
        int n = 0;
        div_mode = m; dividend = a; divisor = b; div_start = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (divider_done || n >= 200) break;
            dividend = {$urandom, $urandom};
            divisor  = {$urandom, $urandom};
            div_mode = 1'($urandom);
            @(posedge clk);
            n++;
        end
        check({nm, " latency"}, 64'(n), 64'd66);
        check({nm, " value"}, div_result, exp);
    endtask

    initial begin
        logic [63:0] a, b;
        logic        m;
        #1 rst_n = 1'b0;
        #1;
        check("reset result", div_result, 64'd0);
        check("reset done", {63'b0, divider_done}, 64'd0);
        check("reset busy", {63'b0, div_busy}, 64'd0);
        check("model sdiv", ref_div(1'b1, N100, 64'd7), N14);
        check("model wrap", ref_div(1'b1, MIN, '1), MIN);
        check("model udiv0", ref_div(1'b0, 64'h1234, 64'd0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 64'd100, 64'd7, 64'd14, "udiv 100/7");
        run_op(1'b1, N100, 64'd7, N14, "sdiv -100/7");
        run_op(1'b1, 64'd100, N7, N14, "sdiv 100/-7");
        run_op(1'b1, N100, N7, 64'd14, "sdiv -100/-7");
        run_op(1'b0, 64'h1234, 64'd0, 64'd0, "udiv by 0");
        run_op(1'b1, 64'h1234, 64'd0, 64'd0, "sdiv by 0");
        run_op(1'b1, MIN, '1, MIN, "sdiv min/-1");
        run_op(1'b0, '1, 64'd1, '1, "udiv max/1");
        run_op(1'b0, 64'd50, 64'd5, 64'd10, "b2b 50/5");
        run_op(1'b0, 64'd81, 64'd9, 64'd9, "b2b 81/9");
        // abort mid-CALC
        div_mode = 1'b0; dividend = 64'd1000; divisor = 64'd3; div_start = 1'b1;
        @(posedge clk);
        repeat (30) @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort result", div_result, 64'd0);
        check("abort done", {63'b0, divider_done}, 64'd0);
        check("abort busy", {63'b0, div_busy}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (70) @(negedge clk);
        run_op(1'b0, 64'd9, 64'd3, 64'd3, "after abort 9/3");
        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = 64'($urandom_range(1, 20));
                2: b = {$urandom, $urandom};
                3: b = '1;
                default: b = {32'd0, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) begin
                div_start = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            run_op(m, a, b, ref_div(m, a, b), "random");
        end
        div_start = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
